// File: rtl/ir_fetch_queue.sv
// Instruction fetch queue: DEPTH-entry FIFO of instruction words with head-entry decode.
// Optional IR_HOLD_LAST_EN: decode outputs keep the last popped word while the queue is empty.
module ir_fetch_queue #(
   parameter int DATA_W    = 16,
   parameter int DEPTH     = 2,
   parameter int IMM_OUT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [7:0]                 opcode,
   output logic [3:0]                 rdst,
   output logic [3:0]                 rsrc,
   output logic [IMM_OUT_W-1:0]       imm_zext,
   output logic [IMM_OUT_W-1:0]       imm_sext,
   output logic [IMM_OUT_W-1:0]       bdisp,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   function automatic logic [IMM_OUT_W-1:0] sext8(input logic [7:0] v);
      return {{(IMM_OUT_W-8){v[7]}}, v};
   endfunction

   function automatic logic [IMM_OUT_W-1:0] zext8(input logic [7:0] v);
      return {{(IMM_OUT_W-8){1'b0}}, v};
   endfunction

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_push;
   logic              w_pop;
   logic [DATA_W-1:0] w_head;
   logic [DATA_W-1:0] w_dec;

   assign in_ready  = (r_count != CNT_W'(DEPTH));
   assign out_valid = (r_count != {CNT_W{1'b0}});
   assign count     = r_count;
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;
   assign w_head    = r_mem[r_rptr];

   // Queue storage, pointers and occupancy; flush overrides push and pop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {DATA_W{1'b0}};
         end
         r_wptr  <= {PTR_W{1'b0}};
         r_rptr  <= {PTR_W{1'b0}};
         r_count <= {CNT_W{1'b0}};
      end else if (flush) begin
         r_wptr  <= {PTR_W{1'b0}};
         r_rptr  <= {PTR_W{1'b0}};
         r_count <= {CNT_W{1'b0}};
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= in_data;
            r_wptr        <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef IR_HOLD_LAST_EN
   logic [DATA_W-1:0] r_hold;

   // Last popped word; a pop discarded by flush is not captured
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hold <= {DATA_W{1'b0}};
      end else if (w_pop && !flush) begin
         r_hold <= w_head;
      end else begin
         r_hold <= r_hold;
      end
   end

   // Decode source: live head, else the held word
   always_comb begin
      w_dec = {DATA_W{1'b0}};
      if (out_valid) begin
         w_dec = w_head;
      end else begin
         w_dec = r_hold;
      end
   end
`else
   // Decode source: live head, else all zeros
   always_comb begin
      w_dec = {DATA_W{1'b0}};
      if (out_valid) begin
         w_dec = w_head;
      end else begin
         w_dec = {DATA_W{1'b0}};
      end
   end
`endif

   assign opcode   = {w_dec[15:12], w_dec[7:4]};
   assign rdst     = w_dec[11:8];
   assign rsrc     = w_dec[3:0];
   assign imm_zext = zext8(w_dec[7:0]);
   assign imm_sext = sext8(w_dec[7:0]);
   assign bdisp    = sext8({w_dec[7:4], w_dec[3:0]});

endmodule

// File: tb/tb_ir_fetch_queue.sv
// Directed self-checking bench for ir_fetch_queue (DEPTH=2, IMM_OUT_W=16, default build).
module tb_ir_fetch_queue;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  opcode;
   logic [3:0]  rdst;
   logic [3:0]  rsrc;
   logic [15:0] imm_zext;
   logic [15:0] imm_sext;
   logic [15:0] bdisp;
   logic [1:0]  count;

   int n_checks;
   int n_errors;

   ir_fetch_queue #(.DATA_W(16), .DEPTH(2), .IMM_OUT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .opcode(opcode), .rdst(rdst), .rsrc(rsrc),
      .imm_zext(imm_zext), .imm_sext(imm_sext), .bdisp(bdisp),
      .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] wrap_words [8];
   logic [7:0]  wrap_op    [8];
   logic [3:0]  wrap_rd    [8];

   initial begin
      n_checks = 0;
      n_errors = 0;
      wrap_words = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718, 16'h293A, 16'h4B5C, 16'h6D7E, 16'h8F90};
      wrap_op    = '{8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89};
      wrap_rd    = '{4'h1, 4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD, 4'hF};

      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
      step();
      step();
      check_value("rst_count",    32'(count), 32'd0);
      check_value("rst_out_valid",32'(out_valid), 32'd0);
      check_value("rst_in_ready", 32'(in_ready), 32'd1);
      check_value("rst_opcode",   32'(opcode), 32'h00);
      check_value("rst_imm_sext", 32'(imm_sext), 32'h0000);
      rst = 1'b1;
      step();

      // Push into empty queue: visible next cycle
      in_valid = 1'b1; in_data = 16'h5A3F;
      check_value("pre_push_valid", 32'(out_valid), 32'd0);
      step();
      in_valid = 1'b0;
      check_value("p1_out_valid", 32'(out_valid), 32'd1);
      check_value("p1_count",     32'(count), 32'd1);
      check_value("p1_opcode",    32'(opcode), 32'h53);
      check_value("p1_rdst",      32'(rdst), 32'hA);
      check_value("p1_rsrc",      32'(rsrc), 32'hF);
      check_value("p1_imm_zext",  32'(imm_zext), 32'h003F);
      check_value("p1_imm_sext",  32'(imm_sext), 32'h003F);
      check_value("p1_bdisp",     32'(bdisp), 32'h003F);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_value("pop1_count",  32'(count), 32'd0);
      check_value("pop1_valid",  32'(out_valid), 32'd0);
      check_value("pop1_opcode", 32'(opcode), 32'h00);
      check_value("pop1_bdisp",  32'(bdisp), 32'h0000);

      // Negative immediate
      in_valid = 1'b1; in_data = 16'h4EF0;
      step();
      in_valid = 1'b0;
      check_value("p2_opcode",   32'(opcode), 32'h4F);
      check_value("p2_rdst",     32'(rdst), 32'hE);
      check_value("p2_rsrc",     32'(rsrc), 32'h0);
      check_value("p2_imm_zext", 32'(imm_zext), 32'h00F0);
      check_value("p2_imm_sext", 32'(imm_sext), 32'hFFF0);
      check_value("p2_bdisp",    32'(bdisp), 32'hFFF0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Fill, overflow attempt, simultaneous push/pop when full
      in_valid = 1'b1; in_data = 16'h1111;
      step();
      in_data = 16'h2222;
      check_value("fill1_in_ready", 32'(in_ready), 32'd1);
      step();
      check_value("full_count",    32'(count), 32'd2);
      check_value("full_in_ready", 32'(in_ready), 32'd0);
      check_value("full_opcode",   32'(opcode), 32'h11);
      in_data = 16'h9999;
      step();
      check_value("ovf_count",  32'(count), 32'd2);
      check_value("ovf_opcode", 32'(opcode), 32'h11);
      in_data = 16'h3333; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check_value("fullpp_count",    32'(count), 32'd1);
      check_value("fullpp_in_ready", 32'(in_ready), 32'd1);
      check_value("fullpp_opcode",   32'(opcode), 32'h22);
      step();
      out_ready = 1'b0;
      check_value("drain_count", 32'(count), 32'd0);
      check_value("drain_valid", 32'(out_valid), 32'd0);

      // Wrap: one word in flight, then concurrent push/pop
      in_valid = 1'b1; in_data = wrap_words[0];
      step();
      check_value("wrap_op_0", 32'(opcode), 32'(wrap_op[0]));
      for (int i = 1; i < 8; i++) begin
         in_data = wrap_words[i]; out_ready = 1'b1;
         step();
         check_value($sformatf("wrap_op_%0d", i), 32'(opcode), 32'(wrap_op[i]));
         check_value($sformatf("wrap_rd_%0d", i), 32'(rdst), 32'(wrap_rd[i]));
         check_value($sformatf("wrap_cnt_%0d", i), 32'(count), 32'd1);
      end
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      check_value("wrap_end_count", 32'(count), 32'd0);

      // Flush with count=2 and same-cycle push and pop
      in_valid = 1'b1; in_data = 16'h1234;
      step();
      in_data = 16'h5678;
      step();
      check_value("pre_flush_count", 32'(count), 32'd2);
      flush = 1'b1; in_data = 16'h7777; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check_value("flush_count",    32'(count), 32'd0);
      check_value("flush_valid",    32'(out_valid), 32'd0);
      check_value("flush_in_ready", 32'(in_ready), 32'd1);
      check_value("flush_opcode",   32'(opcode), 32'h00);
      check_value("flush_imm_sext", 32'(imm_sext), 32'h0000);
      step();
      check_value("flush_hold_count", 32'(count), 32'd0);

      // Flush with count=1 and a push that would otherwise fit
      in_valid = 1'b1; in_data = 16'h4444;
      step();
      flush = 1'b1; in_data = 16'h7777;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check_value("flush1_count", 32'(count), 32'd0);

      // Queue usable after flush
      in_valid = 1'b1; in_data = 16'h5A3F;
      step();
      in_valid = 1'b0;
      check_value("post_flush_opcode", 32'(opcode), 32'h53);
      check_value("post_flush_count",  32'(count), 32'd1);

      // Asynchronous reset between clock edges
      #2;
      rst = 1'b0;
      #1;
      check_value("async_rst_count", 32'(count), 32'd0);
      check_value("async_rst_valid", 32'(out_valid), 32'd0);
      check_value("async_rst_rdst",  32'(rdst), 32'h0);
      step();
      rst = 1'b1;
      step();
      check_value("after_rst_in_ready", 32'(in_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ir_fetch_queue.md
Name: ir_fetch_queue

Overview:
Parametrised instruction register for the CPU datapath: a DEPTH-entry FIFO of fetched instruction words with valid/ready handshakes on both sides. The head entry is decoded into opcode, register, immediate and branch-displacement fields for the controller and register file. It sits between instruction memory read data and the decode/control FSM. Unlike a single enable-loaded register, it buffers prefetched words, supports a flush on taken branches, and provides sign- and zero-extended immediates at a configurable width.

Parameters:
DATA_W, 16, instruction word width; field map below requires DATA_W = 16.
DEPTH, 2, queue entries; power of two, >= 2.
IMM_OUT_W, 16, width of the extended immediate and displacement outputs; >= 8.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous queue clear (taken branch/jump)
in_valid  in  1  instruction word present on in_data
in_data  in  DATA_W  fetched instruction word
in_ready  out  1  queue can accept a word
out_valid  out  1  head entry valid; decode outputs meaningful
out_ready  in  1  consumer accepts the head entry
opcode  out  8  {head[15:12], head[7:4]}
rdst  out  4  head[11:8]
rsrc  out  4  head[3:0]
imm_zext  out  IMM_OUT_W  head[7:0], zero-extended
imm_sext  out  IMM_OUT_W  head[7:0], sign-extended from bit 7
bdisp  out  IMM_OUT_W  {head[7:4], head[3:0]}, sign-extended from bit 7
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (rst = 0, asynchronous): storage pointers and count = 0, out_valid = 0, in_ready = 1, all decode outputs = 0.
- Push when in_valid && in_ready; pop when out_valid && out_ready; evaluated at the rising clock edge.
- in_ready = (count != DEPTH); it depends only on registered state, with no combinational path from out_ready.
- out_valid = (count != 0). Decode outputs derive combinationally from the registered head entry.
- Latency: a word pushed into an empty queue appears at out_valid/opcode in the following cycle. There is no same-cycle bypass.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and the head advances.
- When full, in_ready = 0. A simultaneous pop frees a slot visible next cycle only.
- When empty, a push only: count becomes 1.
- Write and read pointers wrap modulo DEPTH. Count never exceeds DEPTH or underflows.
- flush = 1: next cycle count = 0 and out_valid = 0. Any same-cycle push or pop is discarded. flush has priority over both.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Extension: imm_sext and bdisp replicate bit 7 into bits [IMM_OUT_W-1:8]. imm_zext fills those bits with 0.

Optional Feature:
IR_HOLD_LAST_EN. Defined: a holding register captures the head word on every pop. When out_valid = 0, the decode outputs show the last popped instruction, matching legacy hold-when-not-enabled behaviour. The holding register is cleared by reset only; flush does not clear it. Not defined: decode outputs are forced to 0 whenever out_valid = 0.

Test Plan:
- Reset then idle: rst low for 2 cycles -> count=0, out_valid=0, in_ready=1, opcode=0, imm_sext=0x0000.
- Push 0x5A3F into an empty queue -> next cycle out_valid=1, opcode=0x53, rdst=0xA, rsrc=0xF, imm_zext=0x003F, imm_sext=0x003F.
- Push 0x4EF0 (IMM_OUT_W=16) -> imm_zext=0x00F0, imm_sext=0xFFF0, bdisp=0xFFF0.
- Fill to DEPTH=2 with 0x1111 and 0x2222, out_ready=0 -> in_ready=0. A third push is ignored. Pop twice -> heads 0x1111 then 0x2222, in order.
- Full queue with simultaneous push of 0x3333 and pop -> push is ignored, count=1. Exercise wrap with 8 alternating push/pops -> output order preserved.
- count=2 with flush and push 0x7777 in the same cycle -> next cycle count=0, out_valid=0. Decode outputs are 0 without IR_HOLD_LAST_EN. With IR_HOLD_LAST_EN they equal the last popped word.
